// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised/filtered inputs, 11-bit frame checker
// with per-frame timeout, and a first-word-fall-through byte FIFO with optional inhibit.

module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);
  localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with filt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module ps2_rx_fifo #(
  parameter int FILTER_LEN      = 4,
  parameter int TIMEOUT_CYCLES  = 5000,
  parameter int FIFO_DEPTH      = 8,
  parameter bit INHIBIT_ON_FULL = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ps2_clk_in,
  input  logic                        ps2_data_in,
  output logic                        ps2_clk_oe,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        timeout_err,
  output logic                        overflow,
  input  logic                        ovf_clr
);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CNTW      = AW + 1;
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NUM_LINES = 2;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  // ---- input conditioning: lane 0 = clock, lane 1 = data
  logic [NUM_LINES-1:0] line_raw, line_filt;
  assign line_raw = {ps2_data_in, ps2_clk_in};

  genvar g;
  generate
    for (g = 0; g < NUM_LINES; g++) begin : g_line
      ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (line_raw[g]),
        .filt   (line_filt[g])
      );
    end
  endgenerate

  logic clk_filt_q, fall, din;
  assign fall = clk_filt_q & ~line_filt[0];
  assign din  = line_filt[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_filt_q <= 1'b1;
    else          clk_filt_q <= line_filt[0];
  end

  // ---- frame FSM
  state_t          state, state_nxt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit, stop_bit;
  logic [TW-1:0]   to_cnt;
  logic            to_hit, par_ok, push;

  // a real edge in the same cycle as expiry counts as activity, not a timeout
  assign to_hit = (state == RECV) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall && !din) state_nxt = RECV;
      RECV: begin
        if (to_hit)                        state_nxt = IDLE;
        else if (fall && bit_cnt == 4'd10) state_nxt = CHECK;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
      to_cnt   <= '0;
    end else begin
      if (fall || state != RECV) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;

      if (state == IDLE) begin
        bit_cnt <= 4'd1;
      end else if (state == RECV && fall) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt <= 4'd8)       shreg    <= {din, shreg[7:1]};
        else if (bit_cnt == 4'd9)  par_bit  <= din;
        else                       stop_bit <= din;
      end
    end
  end

  assign par_ok      = ^{par_bit, shreg};
  assign parity_err  = (state == CHECK) && !par_ok;
  assign frame_err   = (state == CHECK) && par_ok && !stop_bit;
  assign push        = (state == CHECK) && par_ok && stop_bit;
  assign timeout_err = to_hit;

  // ---- FWFT FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en;

  assign full  = (count == CNTW'(FIFO_DEPTH));
  assign pop   = rx_ready && rx_valid;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  assign rx_valid   = (count != '0);
  assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;
  assign ps2_clk_oe = INHIBIT_ON_FULL && full && (state == IDLE);
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with a buffered output. It runs entirely in the system clock domain and oversamples the PS/2 clock and data lines through synchronisers and glitch filters. Each 11-bit frame is checked for start, odd parity and stop bits, and a per-frame timeout is enforced. Good bytes are queued in a first-word-fall-through FIFO. Optionally the block inhibits the device by holding the PS/2 clock low while the FIFO is full. It sits between the board's PS/2 pins (open-drain `kbclk`/`kbdata`) and any byte consumer, such as a scan-code decoder or LED debug display.

## Interface
- `FILTER_LEN`, 4: consecutive identical synchronised samples required before a filtered line changes level (≥2).
- `TIMEOUT_CYCLES`, 5000: maximum `clk` cycles between falling edges inside one frame (200 µs at 25 MHz).
- `FIFO_DEPTH`, 8: number of entries; must be a power of two, ≥2.
- `INHIBIT_ON_FULL`, 1: 1 = drive `ps2_clk_oe` while the FIFO is full; 0 = never inhibit.
- `clk` in 1: system clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_clk_in` in 1: raw PS/2 clock pin level (asynchronous).
- `ps2_data_in` in 1: raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe` out 1: 1 = top level drives the PS/2 clock low (inhibit).
- `rx_data` out 8: FIFO head byte; valid only while `rx_valid` = 1.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: pop the head; effective only when `rx_valid` = 1.
- `count` out log2(FIFO_DEPTH)+1: current FIFO occupancy.
- `parity_err` out 1: one-cycle pulse, frame discarded for bad parity.
- `frame_err` out 1: one-cycle pulse, frame discarded because the stop bit was 0.
- `timeout_err` out 1: one-cycle pulse, frame abandoned by timeout.
- `overflow` out 1: sticky; a good frame was dropped because the FIFO was full.
- `ovf_clr` in 1: synchronous clear of `overflow`.

## Operation
- Input path: each line passes through a 2-flop synchroniser, then a filter whose output takes the new level only after `FILTER_LEN` consecutive equal samples. Both filtered levels reset to 1.
- A falling edge on the filtered clock produces a one-cycle `edge` strobe. Filtered data is sampled in the strobe cycle.
- FSM states:
  - IDLE: on `edge` with data = 0, go to RECV with bit count 1. On `edge` with data = 1, ignore the edge (spurious; no error) and stay in IDLE.
  - RECV: shift data bits LSB-first for bits 1–8, bit 9 is parity, bit 10 is stop. On the stop edge go to CHECK.
  - CHECK: runs for one cycle.
    - Parity is odd over data+parity. A parity failure pulses `parity_err`.
    - If parity passes and stop = 0, pulse `frame_err`.
    - If both are good, write the byte into the FIFO. If the FIFO is full and there is no simultaneous pop, drop the byte and set `overflow`.
    - Parity is checked first; exactly one error pulse is issued per frame.
    - Return to IDLE.
- Timeout: a counter clears on every `edge` and increments while in RECV. When it reaches `TIMEOUT_CYCLES`, pulse `timeout_err`, discard the partial frame and go to IDLE.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (no overflow) and when it is empty and pushing (count unchanged is not possible; pop is ignored because `rx_valid` = 0).
  - Pointers wrap modulo `FIFO_DEPTH`.
- Inhibit: `ps2_clk_oe` = `INHIBIT_ON_FULL` & full & (state == IDLE). The block never inhibits mid-frame. While inhibited, the filtered clock reads low, so there are no edges and the FSM holds in IDLE.
- `overflow` clears on `ovf_clr`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: `ps2_clk_oe` = 0, `rx_data` = 0x00, `rx_valid` = 0, `count` = 0, all error pulses = 0, `overflow` = 0. The FSM is in IDLE with counters at 0.
- `edge` asserts 2+`FILTER_LEN` cycles after a clean raw falling edge (fixed latency, ±0).
- The stop-bit `edge` occurs in cycle E. CHECK runs in E+1 and the FIFO write takes effect at the end of E+1. `rx_valid` and `count` update in E+2, and error pulses are high during E+1.
- Pop: `rx_ready` & `rx_valid` in cycle P. The next entry appears on `rx_data` in P+1.
- Reset asserted mid-frame or mid-pop: immediate return to reset values. FIFO contents are lost.

## Test plan
- Byte 0x1C is sent (bits 0,0,0,1,1,1,0,0,0,0,1; parity 0) at 12.5 kHz with `FILTER_LEN`=4 → `rx_valid`=1, `rx_data`=0x1C, `count`=1, and no error pulses. Pop → `count`=0.
- 0x1C is sent with parity 1 → one `parity_err` pulse and `count` stays 0. 0x1C with stop 0 → one `frame_err` pulse.
- Start bit plus 3 data bits, then the clock is held high for 5000 cycles → one `timeout_err` pulse. A following full 0xF0 frame is received correctly.
- `FIFO_DEPTH`=4, `INHIBIT_ON_FULL`=0, frames 0x01–0x05 with no pops → `count`=4 and `overflow`=1. Pops return 0x01..0x04. `ovf_clr` → `overflow`=0.
- `INHIBIT_ON_FULL`=1, 4 frames received → `ps2_clk_oe`=1 in the cycle `count` reaches 4. One pop → `ps2_clk_oe`=0 the next cycle.
- A 2-cycle low glitch on `ps2_clk_in` while idle, and `reset_n` pulsed low after bit 5 of a frame → no capture, no errors, all outputs at reset values. The next frame 0xAA is received correctly.
